// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM state type,
// header field layout, the illegal destination code and header helpers.
package router_pkg;

    localparam int BYTE_W   = 8;
    localparam int DEST_W   = 2;
    localparam int LEN_W    = 6;
    localparam int DEST_LSB = 0;
    localparam int LEN_LSB  = DEST_W;

    // Destination 3 does not exist on the 1x3 router
    localparam logic [DEST_W-1:0] DEST_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    // Header byte carries the length in the upper bits and dest in the lower bits
    function automatic logic [BYTE_W-1:0] build_header(
        input logic [LEN_W-1:0]  len,
        input logic [DEST_W-1:0] dest
    );
        logic [BYTE_W-1:0] hdr;
        hdr                     = '0;
        hdr[LEN_LSB  +: LEN_W]  = len;
        hdr[DEST_LSB +: DEST_W] = dest;
        return hdr;
    endfunction

    // A request is only sendable with a real destination and a non-empty payload
    function automatic logic req_is_legal(
        input logic [DEST_W-1:0] dest,
        input logic [LEN_W-1:0]  len
    );
        return (dest != DEST_ILLEGAL) && (len != '0);
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side byte bus of the packet transmitter.
// The master modport is the transmitter itself; slave is the traffic
// source / router model on the other side.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic                 req_valid;
    logic [DEST_W-1:0]    req_dest;
    logic [LEN_W-1:0]     req_len;
    logic                 req_ready;

    logic [BYTE_W-1:0]    pl_data;
    logic                 pl_valid;
    logic                 pl_ready;

    logic [BYTE_W-1:0]    data;
    logic                 pkt_valid;
    logic                 busy;

    modport master (
        input  req_valid, req_dest, req_len,
        input  pl_data, pl_valid,
        input  busy,
        output req_ready, pl_ready,
        output data, pkt_valid
    );

    modport slave (
        output req_valid, req_dest, req_len,
        output pl_data, pl_valid,
        output busy,
        input  req_ready, pl_ready,
        input  data, pkt_valid
    );

endinterface

// File: rtl/router_err_cnt.sv
// Counts rising edges of the router err line into a saturating counter.
module router_err_cnt #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic err_q;
    logic err_rise;

    assign err_rise = err & ~err_q;

    // Delay err by one cycle and bump the counter on each 0->1 edge, stopping at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_q <= err;
            if (err_rise && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Transmit end of the router input port. Turns a (dest, len) request plus a
// payload byte stream into header / payload / parity bytes on data/pkt_valid,
// holding the current byte while the router reports busy, then forcing IPG
// idle cycles before the next header.
// Optional build macro ROUTER_PAR_INJECT_EN adds the inj_par input, which
// inverts the parity byte of the packet it was sampled with.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int IPG       = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    router_pkt_tx_if.master      bus,
    input  logic                 err,
`ifdef ROUTER_PAR_INJECT_EN
    input  logic                 inj_par,
`endif
    output logic                 pkt_done,
    output logic                 req_drop,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // A zero gap would let the router see parity and the next header back to back
    localparam int IPG_EFF = (IPG < 1) ? 1 : IPG;
    localparam int GAP_W   = $clog2(IPG_EFF + 1);

    tx_state_t          state_q, state_n;
    logic [BYTE_W-1:0]  data_q, data_n;
    logic               pkt_valid_q, pkt_valid_n;
    logic [BYTE_W-1:0]  parity_q, parity_n;
    logic [LEN_W-1:0]   remaining_q, remaining_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic               req_ready_q, req_ready_n;
    logic               pkt_done_q, pkt_done_n;
    logic               req_drop_q, req_drop_n;
    logic               pl_ready_c;

    logic               req_fire;
    logic               req_legal;
    logic [BYTE_W-1:0]  header_byte;
    logic [BYTE_W-1:0]  parity_out;

    assign req_fire    = bus.req_valid && req_ready_q;
    assign req_legal   = req_is_legal(bus.req_dest, bus.req_len);
    assign header_byte = build_header(bus.req_len, bus.req_dest);

`ifdef ROUTER_PAR_INJECT_EN
    logic inj_q;

    // Remember whether this packet should carry a deliberately wrong parity byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && req_fire && req_legal) begin
            inj_q <= inj_par;
        end
    end

    assign parity_out = parity_q ^ {BYTE_W{inj_q}};
`else
    assign parity_out = parity_q;
`endif

    // Next-state and next-output decode; every register holds unless a case below moves it
    always_comb begin
        state_n     = state_q;
        data_n      = data_q;
        pkt_valid_n = pkt_valid_q;
        parity_n    = parity_q;
        remaining_n = remaining_q;
        gap_n       = gap_q;
        pkt_done_n  = 1'b0;
        req_drop_n  = 1'b0;
        pl_ready_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_legal) begin
                        state_n     = ST_HEADER;
                        data_n      = header_byte;
                        pkt_valid_n = 1'b1;
                        parity_n    = header_byte;
                        remaining_n = bus.req_len;
                    end else begin
                        req_drop_n  = 1'b1;
                    end
                end
            end

            ST_HEADER: begin
                if (!bus.busy) begin
                    state_n     = ST_PAYLOAD;
                    pkt_valid_n = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                // With busy low the slot is either empty or handing its byte over this edge
                pl_ready_c = !bus.busy && (remaining_q != '0);
                if (!bus.busy) begin
                    if (pl_ready_c && bus.pl_valid) begin
                        data_n      = bus.pl_data;
                        pkt_valid_n = 1'b1;
                        parity_n    = parity_q ^ bus.pl_data;
                        remaining_n = remaining_q - LEN_W'(1);
                    end else if (pkt_valid_q && (remaining_q == '0)) begin
                        state_n     = ST_PARITY;
                        data_n      = parity_out;
                        pkt_valid_n = 1'b0;
                    end else begin
                        pkt_valid_n = 1'b0;
                    end
                end
            end

            ST_PARITY: begin
                if (!bus.busy) begin
                    state_n    = ST_GAP;
                    data_n     = '0;
                    pkt_done_n = 1'b1;
                    gap_n      = '0;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(IPG_EFF - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_n     = ST_IDLE;
                data_n      = '0;
                pkt_valid_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == ST_IDLE);
    end

    // State and output registers; reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            parity_q    <= '0;
            remaining_q <= '0;
            gap_q       <= '0;
            req_ready_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            req_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            data_q      <= data_n;
            pkt_valid_q <= pkt_valid_n;
            parity_q    <= parity_n;
            remaining_q <= remaining_n;
            gap_q       <= gap_n;
            req_ready_q <= req_ready_n;
            pkt_done_q  <= pkt_done_n;
            req_drop_q  <= req_drop_n;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.pl_ready  = pl_ready_c;
    assign bus.data      = data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign pkt_done      = pkt_done_q;
    assign req_drop      = req_drop_q;

    router_err_cnt #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .err     (err),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: the driver pushes the expected byte
// stream of each accepted request (header, payload, parity) and a monitor
// pops and compares whatever the DUT hands to the router.
module tb_router_pkt_tx;
    import router_pkg::*;

    localparam int IPG       = 2;
    localparam int ERR_CNT_W = 2;
    localparam int MAX_WAIT  = 400;

    typedef struct packed {
        logic       is_parity;
        logic [7:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 err = 1'b0;
    logic                 pkt_done;
    logic                 req_drop;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef ROUTER_PAR_INJECT_EN
    logic                 inj_par = 1'b0;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   drop_pending = 0;
    int   pl_allowed   = 0;
    int   xfer_cnt     = 0;
    logic force_busy   = 1'b0;
    logic rand_busy    = 1'b0;
    logic rand_bit     = 1'b0;
    logic [7:0] pl_buf[64];

    logic       have_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_pv   = 1'b0;
    logic       prev_busy = 1'b0;
    int         gap_left  = 0;
    logic       ready_next = 1'b0;

    router_pkt_tx_if bus();

    router_pkt_tx #(
        .IPG       (IPG),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err      (err),
`ifdef ROUTER_PAR_INJECT_EN
        .inj_par  (inj_par),
`endif
        .pkt_done (pkt_done),
        .req_drop (req_drop),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    assign bus.busy = force_busy | rand_bit;

    // Random router backpressure, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        rand_bit = rand_busy & ($urandom_range(0, 3) == 0);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=no/unexpected event required=expected event at %0t", name, $time);
    endtask

    // Monitor: compare every byte the router takes against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_prev  = 1'b0;
            gap_left   = 0;
            ready_next = 1'b0;
        end else begin
            if (bus.pkt_valid && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    e = exp_q.pop_front();
                    check_output("data_byte", {23'b0, 1'b0, bus.data}, {23'b0, e.is_parity, e.data});
                end
                xfer_cnt++;
            end
            if (pkt_done) begin
                check_output("parity_slot", {29'b0, have_prev, prev_pv, prev_busy}, 32'h4);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pkt_done");
                end else begin
                    e = exp_q.pop_front();
                    check_output("parity_byte", {23'b0, 1'b1, prev_data}, {23'b0, e.is_parity, e.data});
                end
                xfer_cnt++;
                gap_left = IPG;
            end
            if (have_prev && prev_pv && prev_busy) begin
                check_output("busy_hold", {23'b0, bus.pkt_valid, bus.data}, {23'b0, 1'b1, prev_data});
            end
            if (gap_left > 0) begin
                check_output("gap_idle", {22'b0, bus.req_ready, bus.pkt_valid, bus.data}, 32'h0);
                gap_left--;
                if (gap_left == 0) ready_next = 1'b1;
            end else if (ready_next) begin
                check_output("ready_after_gap", {31'b0, bus.req_ready}, 32'h1);
                ready_next = 1'b0;
            end
            if (req_drop) begin
                check_output("req_drop_expected", {31'b0, drop_pending > 0}, 32'h1);
                if (drop_pending > 0) drop_pending--;
            end
            if (bus.pl_ready) begin
                check_output("pl_ready_allowed", {31'b0, pl_allowed > 0}, 32'h1);
                if (bus.pl_valid && pl_allowed > 0) pl_allowed--;
            end
            prev_data = bus.data;
            prev_pv   = bus.pkt_valid;
            prev_busy = bus.busy;
            have_prev = 1'b1;
        end
    end

    // Present a request, wait for acceptance and push the expected packet
    task automatic issue_request(input logic [1:0] dest, input logic [5:0] len, input logic inj, output bit accepted);
        bit         legal;
        logic [7:0] par;
        exp_t       e;
        legal         = (dest != 2'd3) && (len != 6'd0);
        accepted      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_dest  = dest;
        bus.req_len   = len;
`ifdef ROUTER_PAR_INJECT_EN
        inj_par = inj;
`endif
        for (int w = 0; w < MAX_WAIT; w++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            fail_now("req_accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        if (!legal) begin
            drop_pending++;
        end else begin
            par = {len, dest};
            e   = '{is_parity: 1'b0, data: {len, dest}};
            exp_q.push_back(e);
            for (int i = 0; i < int'(len); i++) begin
                e = '{is_parity: 1'b0, data: pl_buf[i]};
                exp_q.push_back(e);
                par = par ^ pl_buf[i];
            end
            if (inj) par = ~par;
            e = '{is_parity: 1'b1, data: par};
            exp_q.push_back(e);
            pl_allowed += int'(len);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_dest  = 2'($urandom);
        bus.req_len   = 6'($urandom);
    endtask

    // Stream len payload bytes with optional bubbles and an optional 4-cycle busy hold
    task automatic feed_payload(input int len, input int bubble_fixed, input int bubble_max, input int hold_idx);
        int nb;
        bit done;
        for (int i = 0; i < len; i++) begin
            nb = (i == 0) ? 0 : bubble_fixed;
            if (bubble_max > 0) nb += $urandom_range(0, bubble_max);
            repeat (nb) begin
                @(posedge clk);
                #1;
            end
            bus.pl_valid = 1'b1;
            bus.pl_data  = pl_buf[i];
            done = 1'b0;
            for (int w = 0; w < MAX_WAIT; w++) begin
                @(negedge clk);
                if (bus.pl_ready) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) begin
                fail_now("payload_timeout");
                bus.pl_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.pl_valid = 1'b0;
            bus.pl_data  = 8'($urandom);
            if (i == hold_idx) begin
                force_busy = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check_output("hold_data", {24'b0, bus.data}, {24'b0, pl_buf[i]});
                    check_output("hold_valid", {31'b0, bus.pkt_valid}, 32'h1);
                    @(posedge clk);
                    #1;
                end
                force_busy = 1'b0;
            end
        end
    endtask

    // Wait until the scoreboard drains and the transmitter is back in idle
    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int w = 0; w < MAX_WAIT; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && drop_pending == 0 && bus.req_ready && gap_left == 0 && !ready_next) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("packet_done_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] dest, input logic [5:0] len, input logic inj,
                                  input int bubble_fixed, input int bubble_max, input int hold_idx);
        bit acc;
        issue_request(dest, len, inj, acc);
        if (acc && dest != 2'd3 && len != 6'd0) feed_payload(int'(len), bubble_fixed, bubble_max, hold_idx);
        wait_done();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pl_buf[i] = 8'($urandom);
    endtask

    initial begin
        #(800000);
        $display("[TB] FAIL watchdog: actual=still running required=finished at %0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         base;
        bit         acc;
        bit         ok;
        int         exp_err;
        logic [1:0] dest;
        logic [5:0] len;

        bus.req_valid = 1'b0;
        bus.req_dest  = 2'd0;
        bus.req_len   = 6'd0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = 8'd0;

        // Reset values while reset is held
        #3;
        check_output("rst_data", {24'b0, bus.data}, 32'h0);
        check_output("rst_ctrl", {27'b0, bus.pkt_valid, bus.req_ready, bus.pl_ready, pkt_done, req_drop}, 32'h0);
        check_output("rst_err_cnt", {30'b0, err_cnt}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic send");
        pl_buf[0] = 8'hA5; pl_buf[1] = 8'h3C; pl_buf[2] = 8'hFF;
        apply_stimulus(2'd1, 6'd3, 1'b0, 0, 0, -1);

        $display("[TB] backpressure on second payload byte");
        apply_stimulus(2'd1, 6'd3, 1'b0, 0, 0, 1);

        $display("[TB] illegal requests");
        apply_stimulus(2'd3, 6'd4, 1'b0, 0, 0, -1);
        apply_stimulus(2'd0, 6'd0, 1'b0, 0, 0, -1);

        $display("[TB] payload bubbles");
        fill_random(2);
        apply_stimulus(2'd2, 6'd2, 1'b0, 3, 0, -1);

        $display("[TB] maximum length");
        fill_random(63);
        rand_busy = 1'b1;
        apply_stimulus(2'd2, 6'd63, 1'b0, 0, 1, -1);
        rand_busy = 1'b0;

        $display("[TB] reset mid-packet");
        @(posedge clk);
        #1;
        fill_random(4);
        base = xfer_cnt;
        issue_request(2'd2, 6'd4, 1'b0, acc);
        if (acc) feed_payload(1, 0, 0, -1);
        ok = 1'b0;
        for (int w = 0; w < MAX_WAIT; w++) begin
            if (xfer_cnt >= base + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("mid_packet_timeout");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("midrst_data", {24'b0, bus.data}, 32'h0);
        check_output("midrst_ctrl", {27'b0, bus.pkt_valid, bus.req_ready, bus.pl_ready, pkt_done, req_drop}, 32'h0);
        exp_q.delete();
        pl_allowed   = 0;
        drop_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fill_random(1);
        apply_stimulus(2'd0, 6'd1, 1'b0, 0, 0, -1);

        $display("[TB] randomized traffic");
        rand_busy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            dest = 2'($urandom_range(0, 3));
            len  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
            fill_random(int'(len));
`ifdef ROUTER_PAR_INJECT_EN
            apply_stimulus(dest, len, 1'($urandom), 0, 2, -1);
`else
            apply_stimulus(dest, len, 1'b0, 0, 2, -1);
`endif
        end
        rand_busy = 1'b0;
        check_output("drops_outstanding", 32'(drop_pending), 32'h0);

        $display("[TB] err counting");
        exp_err = 0;
        @(posedge clk);
        #1;
        err = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        err = 1'b0;
        exp_err = (exp_err < (1 << ERR_CNT_W) - 1) ? exp_err + 1 : exp_err;
        @(negedge clk);
        check_output("err_cnt_level", {30'b0, err_cnt}, 32'(exp_err));
        for (int p = 0; p < 4; p++) begin
            @(posedge clk);
            #1;
            err = 1'b1;
            @(posedge clk);
            #1;
            err = 1'b0;
            exp_err = (exp_err < (1 << ERR_CNT_W) - 1) ? exp_err + 1 : exp_err;
            @(negedge clk);
            check_output("err_cnt_pulse", {30'b0, err_cnt}, 32'(exp_err));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Transmit end of the router input port: converts a packet request plus a payload byte stream into the router's byte protocol on data/pkt_valid.
- Packet format: header byte = {len[5:0], dest[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes).
- Honours router busy backpressure, counts router err reports, and sits between stimulus/traffic logic and the 1x3 router input.

Parameters:
- IPG, 2, idle cycles forced after each parity byte before the next header (min 1)
- ERR_CNT_W, 8, width of saturating router-error counter

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-high
- req_valid  in  1  packet request valid
- req_dest  in  2  destination port (0..2; 3 is illegal)
- req_len  in  6  payload length in bytes (1..63; 0 is illegal)
- req_ready  out  1  request accepted when req_valid && req_ready
- pl_data  in  8  payload byte
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  payload byte consumed when pl_valid && pl_ready
- data  out  8  byte to router
- pkt_valid  out  1  high during header and payload bytes, low on the parity byte
- busy  in  1  router busy; current byte holds while high
- err  in  1  router parity-error indication
- pkt_done  out  1  one-cycle pulse when the parity byte transfers
- req_drop  out  1  one-cycle pulse when an illegal request is accepted and discarded
- err_cnt  out  ERR_CNT_W  saturating count of err rising edges

Behaviour:
- Reset values: data=0, pkt_valid=0, req_ready=0, pl_ready=0, pkt_done=0, req_drop=0, err_cnt=0, FSM=IDLE, parity accumulator=0.
- Transfer rule: a byte presented in HEADER, PAYLOAD or PARITY transfers on a rising edge with busy==0. With busy==1, data and pkt_valid hold stable and the FSM does not advance.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - req_ready=1.
  - On accept of a legal request: latch dest/len, register header byte onto data with pkt_valid=1, parity=header, remaining=len, go HEADER.
  - On accept of an illegal request (dest==3 or len==0): pulse req_drop next cycle, stay IDLE, no bytes driven.
- HEADER: on transfer, go PAYLOAD; data/pkt_valid are then driven from the payload stage.
- PAYLOAD:
  - pl_ready = (busy==0) && (data slot empty or transferring).
  - Each accepted pl_data is registered to data with pkt_valid=1, parity ^= byte, remaining--.
  - If pl_valid is low, pkt_valid drops to 0 (bubble) and the router idles; this is legal only because the router ignores bytes with pkt_valid=0 outside parity. After the last byte transfers, go PARITY.
- PARITY: data=parity, pkt_valid=0. On transfer, pulse pkt_done, go GAP.
- GAP: pkt_valid=0, data=0 for IPG cycles, then IDLE.
- Latency: header is on data the cycle after request accept. Minimum packet duration is len+2 transfer cycles plus IPG.
- req_ready is 0 outside IDLE. pl_ready is 0 outside PAYLOAD and never asserted beyond len bytes per packet.
- err: counter increments on each 0->1 edge of err in any state and saturates at all-ones. The edge detector register is reset to 0.
- Simultaneous busy rising and the final payload accept: the byte is held, not lost; parity is computed over accepted bytes only.
- Reset mid-packet: all state clears immediately (async). The partial packet is abandoned and the router is left to time out; no parity byte is sent.

Optional Feature:
- ROUTER_PAR_INJECT_EN defined: adds input inj_par (1 bit), sampled on request accept; when set, the parity byte for that packet is inverted (~parity) to provoke router err.
- Not defined: port absent and parity is always correct.

Decomposition:
- Package router_pkg:
  - state enum typedef
  - header field widths and positions (DEST_W=2, LEN_W=6)
  - illegal dest constant 2'b11
  - function for header byte assembly
- Sub-module router_err_cnt: err edge detect plus saturating counter, parameterised by ERR_CNT_W.

Test Plan:
- Basic send: req dest=1, len=3, payload A5,3C,FF, busy=0 -> data sequence 0D,A5,3C,FF,6B with pkt_valid 1,1,1,1,0; pkt_done pulses once; req_ready high again after 2 GAP cycles.
- Backpressure: same packet, busy=1 for 4 cycles while second payload byte is on data -> data=3C and pkt_valid=1 held stable all 4 cycles; final sequence identical.
- Illegal requests: dest=3 len=4, then dest=0 len=0 -> two req_drop pulses, pkt_valid never asserted, pl_ready never asserted.
- Payload bubbles: len=2, pl_valid low 3 cycles between bytes -> pkt_valid low during the gap; parity byte = header^b0^b1.
- Err counting and saturation: with ERR_CNT_W=2, pulse err 5 times -> err_cnt 1,2,3,3,3; level-held err counts once.
- Reset mid-packet: assert rst after header plus one payload byte -> all outputs 0 same cycle; after release a new len=1 packet is sent correctly with fresh parity.
